// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file: widths, register count
// and the pending-writer counter range.
package regfile_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);
    localparam int CW_DEF   = 2;
    localparam int CMAX_DEF = (1 << CW_DEF) - 1;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating pending-writer counter for one architectural register.
// Issue and writeback in the same cycle cancel; clear wins over both.
module sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          underflow
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          sat;
    logic          zero;

    assign sat  = (count_reg == CMAX);
    assign zero = (count_reg == '0);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !dec && !sat) begin
            count_next = count_reg + 1'b1;
        end else if (dec && !inc && !zero) begin
            count_next = count_reg - 1'b1;
        end
    end

    // A writeback with nothing outstanding is an error unless a flush discards it.
    assign underflow = dec & zero & ~clr;
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational write-through read ports and a per-register
// pending-writer scoreboard that drives the ID-stage stall.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRD  = 2,
    parameter int  CW   = CW_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD-1:0]    re,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ok,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              flush,
    output logic              stall_req,
    output logic              err
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [XLEN-1:0] mem_reg [NREG];
    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:1] underflow;
    logic            iss_ok_int;
    logic            err_reg;

    // Register 0 has no counter and can never look busy.
    assign cnt[0] = '0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            logic inc;
            logic dec;
            assign inc = iss_valid & iss_ok & (iss_rd == AW'(gi));
            assign dec = we & (waddr == AW'(gi));
            sb_cnt #(.CW(CW)) u_cnt (
                .clk       (clk),
                .srst      (rst),
                .inc       (inc),
                .dec       (dec),
                .clr       (flush),
                .count     (cnt[gi]),
                .underflow (underflow[gi])
            );
        end
    endgenerate

    // A same-cycle writeback frees one slot, so a full counter can still accept.
    assign iss_ok_int = ~((cnt[iss_rd] == CMAX) & ~(we & (waddr == iss_rd)));
    assign iss_ok     = rst | iss_ok_int;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [CW-1:0] c;
            logic          hit;
            logic          pending;
            assign addr    = raddr[gi*AW +: AW];
            assign c       = cnt[addr];
            assign hit     = we & (waddr == addr);
            assign pending = hit ? (c > CW'(1)) : (c != '0);
            assign rdata[gi*XLEN +: XLEN] =
                (rst | ~re[gi] | (addr == '0)) ? '0 : (hit ? wdata : mem_reg[addr]);
            assign rbusy[gi] = ~rst & re[gi] & (addr != '0) & pending;
        end
    endgenerate

    assign stall_req = ~rst & ((|rbusy) | (iss_valid & ~iss_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_reg[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (|underflow) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: write-through reads, scoreboard counting,
// saturation, flush and reset priority.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              iss_ok;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [XLEN-1:0]   wdata;
    logic              flush;
    logic              stall_req;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ok    (iss_ok),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .flush     (flush),
        .stall_req (stall_req),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0; re = '0; raddr = '0; iss_valid = 1'b0; iss_rd = '0;
        we = 1'b0; waddr = '0; wdata = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re = 2'b11;
        raddr = {a1, a0};
    endtask

    initial begin
        // Reset with every other control asserted
        idle();
        rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4; we = 1'b1; waddr = 5'd5;
        wdata = 32'hCAFE_0001; flush = 1'b1; rd(5'd5, 5'd4);
        #1;
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_rbusy", {30'b0, rbusy}, 32'h0);
        chk("rst_stall", {31'b0, stall_req}, 32'h0);
        chk("rst_iss_ok", {31'b0, iss_ok}, 32'h1);
        tick();
        idle();
        rd(5'd5, 5'd4);
        #1;
        chk("post_rst_r5", rdata[31:0], 32'h0);
        chk("post_rst_err", {31'b0, err}, 32'h0);

        // Plain write then read
        idle(); we = 1'b1; waddr = 5'd5; wdata = 32'h1234_ABCD;
        tick();
        idle(); re = 2'b01; raddr = {5'd0, 5'd5};
        #1;
        chk("r5_read", rdata[31:0], 32'h1234_ABCD);
        chk("r5_busy", {31'b0, rbusy[0]}, 32'h0);
        chk("err_after_uf", {31'b0, err}, 32'h1);

        // Same-cycle write-through on both ports; r0 hardwired
        idle(); we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; rd(5'd7, 5'd7);
        #1;
        chk("wt_port0", rdata[31:0], 32'hDEAD_BEEF);
        chk("wt_port1", rdata[63:32], 32'hDEAD_BEEF);
        tick();
        idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; rd(5'd0, 5'd7);
        #1;
        chk("r0_wt", rdata[31:0], 32'h0);
        chk("r7_stored", rdata[63:32], 32'hDEAD_BEEF);
        tick();
        idle(); rd(5'd0, 5'd7); re = 2'b01;
        #1;
        chk("r0_read", rdata[31:0], 32'h0);
        chk("re_off_zero", rdata[63:32], 32'h0);

        // Reset clears sticky err and storage
        idle(); rst = 1'b1;
        tick();
        idle(); rd(5'd7, 5'd5);
        #1;
        chk("err_cleared", {31'b0, err}, 32'h0);
        chk("r7_cleared", rdata[31:0], 32'h0);

        // Two issues to r3, drained by two writebacks
        idle(); iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        tick();
        idle(); rd(5'd3, 5'd0); re = 2'b01;
        #1;
        chk("r3_busy2", {31'b0, rbusy[0]}, 32'h1);
        chk("r3_stall", {31'b0, stall_req}, 32'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h3333_0001;
        #1;
        chk("r3_busy_1st_we", {31'b0, rbusy[0]}, 32'h1);
        tick();
        wdata = 32'h3333_0002;
        #1;
        chk("r3_free_2nd_we", {31'b0, rbusy[0]}, 32'h0);
        chk("r3_data_wt", rdata[31:0], 32'h3333_0002);
        tick();
        idle(); rd(5'd3, 5'd0); re = 2'b01;
        #1;
        chk("r3_idle", {31'b0, rbusy[0]}, 32'h0);
        chk("r3_no_err", {31'b0, err}, 32'h0);

        // Saturation on r4 at CMAX=3
        for (int i = 0; i < 3; i++) begin
            idle(); iss_valid = 1'b1; iss_rd = 5'd4;
            #1;
            chk("r4_iss_ok", {31'b0, iss_ok}, 32'h1);
            tick();
        end
        idle(); iss_valid = 1'b1; iss_rd = 5'd4;
        #1;
        chk("r4_full_ok", {31'b0, iss_ok}, 32'h0);
        chk("r4_full_stall", {31'b0, stall_req}, 32'h1);
        tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h4;
        #1;
        chk("r4_full_we_ok", {31'b0, iss_ok}, 32'h1);
        chk("r4_full_we_stl", {31'b0, stall_req}, 32'h0);
        tick();
        idle(); iss_valid = 1'b1; iss_rd = 5'd4;
        #1;
        chk("r4_still_full", {31'b0, iss_ok}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(); we = 1'b1; waddr = 5'd4; wdata = 32'h40 + i; rd(5'd4, 5'd0); re = 2'b01;
            #1;
            chk("r4_drain_busy", {31'b0, rbusy[0]}, (i < 2) ? 32'h1 : 32'h0);
            tick();
        end
        idle();
        #1;
        chk("r4_drain_err", {31'b0, err}, 32'h0);

        // Flush overrides issue and decrement but still writes storage
        idle(); iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        idle(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'h55;
        tick();
        idle(); rd(5'd9, 5'd0); re = 2'b01;
        #1;
        chk("r9_data", rdata[31:0], 32'h55);
        chk("r9_busy", {31'b0, rbusy[0]}, 32'h0);
        chk("r9_err0", {31'b0, err}, 32'h0);
        idle(); we = 1'b1; waddr = 5'd9; wdata = 32'h66;
        tick();
        idle();
        #1;
        chk("r9_err1", {31'b0, err}, 32'h1);
        tick();
        tick();
        chk("err_sticky", {31'b0, err}, 32'h1);

        // Reset dominates issue, writeback and flush
        idle(); rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd2; we = 1'b1;
        waddr = 5'd2; wdata = 32'h77; flush = 1'b1; rd(5'd2, 5'd9);
        #1;
        chk("rst2_iss_ok", {31'b0, iss_ok}, 32'h1);
        chk("rst2_rdata0", rdata[31:0], 32'h0);
        tick();
        idle(); rd(5'd2, 5'd9);
        #1;
        chk("rst2_err", {31'b0, err}, 32'h0);
        chk("rst2_r2", rdata[31:0], 32'h0);
        chk("rst2_r9", rdata[63:32], 32'h0);
        chk("rst2_rbusy", {30'b0, rbusy}, 32'h0);
        idle(); iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        idle(); we = 1'b1; waddr = 5'd2; wdata = 32'h88; rd(5'd2, 5'd0); re = 2'b01;
        #1;
        chk("rst2_cnt_one", {31'b0, rbusy[0]}, 32'h0);
        tick();
        idle();
        #1;
        chk("rst2_no_uf", {31'b0, err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
